// File: rtl/mul_host_uart_driver.sv
// Host-side driver for the UART multiplier core: sends A then B as 8N1
// frames, collects the two-byte product reply, and reports done or error.
module mul_host_uart_driver #(
  parameter logic [25:0] CLOCK_FREQ   = 26'd50000000,
  parameter logic [23:0] BAUD_RATE    = 24'd9600,
  parameter int          TX_GAP       = 100,
  parameter int          RESP_TIMEOUT = 2000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        mul_enable,
  output logic        busy,
  output logic [15:0] product,
  output logic        done,
  output logic        timeout_err
);

  localparam logic [31:0] CPB      = 32'(CLOCK_FREQ) / 32'(BAUD_RATE);
  localparam logic [31:0] BIT_END  = CPB - 32'd1;
  localparam logic [31:0] HALF_END = (CPB >> 1) - 32'd1;
  localparam logic [31:0] GAP_END  = 32'(TX_GAP) - 32'd1;
  localparam logic [31:0] TMO_END  = 32'(RESP_TIMEOUT) - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_A, S_GAP, S_SEND_B, S_WAIT
  } state_e;

  typedef enum logic [1:0] {
    R_HUNT, R_START, R_DATA, R_STOP
  } rx_state_e;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        tx_q, tx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  stage_q, stage_d;
  logic        nbytes_q, nbytes_d;
  logic [15:0] product_q, product_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  rx_state_e   rst_q, rst_d;
  logic        s1_q, s2_q, s3_q;
  logic [31:0] rcnt_q, rcnt_d;
  logic [2:0]  rbit_q, rbit_d;
  logic [7:0]  rsh_q, rsh_d;

  logic        rx_ok;
  logic        rx_ferr;
  logic [9:0]  frame;

  // Stop-bit centre: good byte if line high, framing error if low.
  assign rx_ok   = (rst_q == R_STOP) && (rcnt_q == BIT_END) && s2_q;
  assign rx_ferr = (rst_q == R_STOP) && (rcnt_q == BIT_END) && !s2_q;

  always_comb begin
    rst_d  = rst_q;
    rcnt_d = rcnt_q;
    rbit_d = rbit_q;
    rsh_d  = rsh_q;
    unique case (rst_q)
      R_HUNT: begin
        if (s3_q && !s2_q) begin
          rst_d  = R_START;
          rcnt_d = '0;
        end
      end
      R_START: begin
        if (rcnt_q == HALF_END) begin
          rcnt_d = '0;
          rbit_d = '0;
          rst_d  = s2_q ? R_HUNT : R_DATA;
        end else begin
          rcnt_d = rcnt_q + 32'd1;
        end
      end
      R_DATA: begin
        if (rcnt_q == BIT_END) begin
          rcnt_d = '0;
          rsh_d  = {s2_q, rsh_q[7:1]};
          if (rbit_q == 3'd7) rst_d = R_STOP;
          else rbit_d = rbit_q + 3'd1;
        end else begin
          rcnt_d = rcnt_q + 32'd1;
        end
      end
      R_STOP: begin
        if (rcnt_q == BIT_END) begin
          rcnt_d = '0;
          rst_d  = R_HUNT;
        end else begin
          rcnt_d = rcnt_q + 32'd1;
        end
      end
      default: rst_d = R_HUNT;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    tx_d      = tx_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    stage_d   = stage_q;
    nbytes_d  = nbytes_q;
    product_d = product_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    frame     = {1'b1, (state_q == S_SEND_B) ? b_q : a_q, 1'b0};
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          tx_d    = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_SEND_A;
        end
      end
      S_SEND_A, S_SEND_B: begin
        if (cnt_q == BIT_END) begin
          cnt_d = '0;
          if (bit_q == 4'd9) begin
            tx_d     = 1'b1;
            nbytes_d = 1'b0;
            state_d  = (state_q == S_SEND_A) ? S_GAP : S_WAIT;
          end else begin
            bit_d = bit_q + 4'd1;
            tx_d  = frame[bit_q + 4'd1];
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_END) begin
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = 1'b0;
          state_d = S_SEND_B;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        // A completing second byte beats a coincident timeout.
        if (rx_ok && nbytes_q) begin
          product_d = {rsh_q, stage_q};
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else if (rx_ferr || cnt_q == TMO_END) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (rx_ok) begin
          stage_d  = rsh_q;
          nbytes_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      tx_q      <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      stage_q   <= '0;
      nbytes_q  <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rst_q     <= R_HUNT;
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      s3_q      <= 1'b1;
      rcnt_q    <= '0;
      rbit_q    <= '0;
      rsh_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tx_q      <= tx_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      stage_q   <= stage_d;
      nbytes_q  <= nbytes_d;
      product_q <= product_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rst_q     <= rst_d;
      s1_q      <= uart_rx;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      rcnt_q    <= rcnt_d;
      rbit_q    <= rbit_d;
      rsh_q     <= rsh_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign mul_enable  = busy;
  assign uart_tx     = tx_q;
  assign product     = product_q;
  assign done        = done_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mul_host_uart_driver.sv
// Directed bench for mul_host_uart_driver: frame shapes, replies,
// timeout, framing error, glitch rejection and mid-frame reset.
module tb_mul_host_uart_driver;

  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  op_a;
  logic [7:0]  op_b;
  logic        uart_rx;
  logic        uart_tx;
  logic        mul_enable;
  logic        busy;
  logic [15:0] product;
  logic        done;
  logic        timeout_err;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  mul_host_uart_driver #(
    .CLOCK_FREQ  (26'd1000000),
    .BAUD_RATE   (24'd100000),
    .TX_GAP      (20),
    .RESP_TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .uart_rx    (uart_rx),
    .uart_tx    (uart_tx),
    .mul_enable (mul_enable),
    .busy       (busy),
    .product    (product),
    .done       (done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (timeout_err) err_cnt++;
    if (done && timeout_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic [7:0] a, input logic [7:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_en", 32'(mul_enable), 32'd1);
  endtask

  task automatic frame_chk(input string tag, input logic [7:0] b,
                           input bit noisy);
    logic [9:0] exp;
    logic [9:0] got;
    exp = {1'b1, b, 1'b0};
    got = '0;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 10; j++) begin
        start = noisy && (j == 2);
        if (noisy) op_a = 8'hEE;
        tick();
        if (j == 4) got[k] = uart_tx;
      end
    end
    start = 1'b0;
    check(tag, 32'(got), 32'(exp));
  endtask

  task automatic gap_chk();
    int hi;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      hi += int'(uart_tx);
      tick();
    end
    check("gap_high", 32'(hi), 32'd20);
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] b,
                     input bit noisy);
    start_txn(a, b);
    frame_chk("frame_a", a, noisy);
    gap_chk();
    frame_chk("frame_b", b, noisy);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (10) tick();
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (10) tick();
    end
    uart_rx = stop;
    repeat (10) tick();
    uart_rx = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int e0;
    reset   = 1'b0;
    start   = 1'b0;
    op_a    = '0;
    op_b    = '0;
    uart_rx = 1'b1;
    repeat (3) tick();
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_en", 32'(mul_enable), 32'd0);
    check("rst_prod", 32'(product), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    reset = 1'b1;
    tick();

    // 1: 0x0C * 0x0D
    d0 = done_cnt;
    txn(8'h0C, 8'h0D, 1'b0);
    send_byte(8'h9C, 1'b1);
    check("t1_staging", 32'(product), 32'h0);
    send_byte(8'h00, 1'b1);
    check("t1_prod", 32'(product), 32'h009C);
    check("t1_done", 32'(done_cnt - d0), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_en", 32'(mul_enable), 32'd0);

    // 2: 0xFF * 0xFF, then product held during the next transaction
    txn(8'hFF, 8'hFF, 1'b0);
    send_byte(8'h01, 1'b1);
    send_byte(8'hFE, 1'b1);
    check("t2_prod", 32'(product), 32'hFE01);
    d0 = done_cnt;
    txn(8'h02, 8'h03, 1'b0);
    check("t2_hold_a", 32'(product), 32'hFE01);
    send_byte(8'h06, 1'b1);
    check("t2_hold_b", 32'(product), 32'hFE01);
    send_byte(8'h00, 1'b1);
    check("t2_prod2", 32'(product), 32'h0006);
    check("t2_done", 32'(done_cnt - d0), 32'd1);

    // 3: no reply -> timeout exactly TMO clocks after WAIT_RESP entry
    d0 = done_cnt;
    e0 = err_cnt;
    txn(8'h07, 8'h09, 1'b0);
    repeat (TMO - 1) tick();
    check("t3_early", 32'(timeout_err), 32'd0);
    check("t3_busy_wait", 32'(busy), 32'd1);
    tick();
    check("t3_err", 32'(timeout_err), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_prod", 32'(product), 32'h0006);
    tick();
    check("t3_err_pulse", 32'(err_cnt - e0), 32'd1);
    check("t3_no_done", 32'(done_cnt - d0), 32'd0);
    txn(8'h03, 8'h05, 1'b0);
    send_byte(8'h0F, 1'b1);
    send_byte(8'h00, 1'b1);
    check("t3_next", 32'(product), 32'h000F);

    // 4: framing error on second byte, then a glitch before a good reply
    d0 = done_cnt;
    e0 = err_cnt;
    txn(8'h04, 8'h04, 1'b0);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b0);
    check("t4_ferr", 32'(err_cnt - e0), 32'd1);
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);
    check("t4_prod", 32'(product), 32'h000F);
    check("t4_idle", 32'(busy), 32'd0);
    txn(8'h06, 8'h07, 1'b0);
    uart_rx = 1'b0;
    repeat (3) tick();
    uart_rx = 1'b1;
    repeat (20) tick();
    check("t4_glitch_busy", 32'(busy), 32'd1);
    send_byte(8'h2A, 1'b1);
    send_byte(8'h00, 1'b1);
    check("t4_glitch_prod", 32'(product), 32'h002A);
    check("t4_glitch_err", 32'(err_cnt - e0), 32'd1);

    // 5: reset mid-frame, then a clean transaction with start noise
    start_txn(8'h55, 8'h01);
    repeat (45) tick();
    #2 reset = 1'b0;
    #1;
    check("t5_tx", 32'(uart_tx), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_en", 32'(mul_enable), 32'd0);
    check("t5_prod", 32'(product), 32'h0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    d0 = done_cnt;
    txn(8'h5A, 8'h02, 1'b1);
    send_byte(8'hB4, 1'b1);
    send_byte(8'h00, 1'b1);
    check("t5_prod2", 32'(product), 32'h00B4);
    check("t5_done", 32'(done_cnt - d0), 32'd1);
    check("t5_idle", 32'(busy), 32'd0);
    check("never_both", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
